mii_rx_frame: RTL and testbench

//  MII receive-side framer: the inbound counterpart of the MII transmit path. Takes nibbles from the PHY,

---
 rtl/mii_rx_frame.sv | 210 +++++++++++++++++++++
 tb/tb_mii_rx_frame.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_frame.sv
// mii_rx_frame: MII receive-side framer.
// Takes PHY nibbles, strips preamble/SFD, walks the 14-byte MAC header,
// checks the Ethernet FCS and delivers payload bytes, a 24-bit frame id
// (first three payload bytes) and a one-cycle good/bad verdict per frame.
// Build option: define MII_RX_MAC_FILTER_EN to accept only frames addressed
// to STATION_MAC or broadcast. Other frames are dropped silently.
//
// Output protocol: rx_valid is a single-cycle strobe with no ready/backpressure.
// The consumer must take rx_data in the cycle rx_valid is high. Bytes of a
// frame that later ends in frame_bad may already have been delivered, so the
// consumer discards them on frame_bad.
module mii_rx_frame #(
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter logic [47:0] STATION_MAC = 48'h0000_0000_0001
) (
  input  logic        phy_rxclk,
  input  logic        reset,
  input  logic [3:0]  phy_rxd,
  input  logic        phy_rxdv,
  input  logic        phy_rxer,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [23:0] frameid,
  output logic        frame_good,
  output logic        frame_bad,
  output logic        rx_busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_DATA = 3'd3,
    S_DROP = 3'd4
  } state_t;

  // CRC is kept MSB-first with bits fed LSB-first. Over data plus FCS it
  // leaves this fixed residue.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  // DATA byte k is emitted as payload byte k-4. Emission stops at MAX_PAYLOAD.
  localparam logic [11:0] EMIT_LIMIT  = 12'(MAX_PAYLOAD + 4);
  localparam logic [4:0]  HDR_LAST    = 5'd27;
  localparam logic [10:0] BYTE_SAT    = 11'h7FF;

  state_t          state_q;
  logic [31:0]     crc_q;
  logic [31:0]     crc_d;
  logic [4:0]      hdr_cnt_q;
  logic [10:0]     byte_cnt_q;
  logic            phase_q;
  logic [3:0]      lo_q;
  logic [3:0][7:0] dly_q;
  logic [7:0]      byte_d;
  logic [15:0]     fid_lo_q;
  logic            err_q;
  logic            ovr_q;
  logic            data_bad;

`ifdef MII_RX_MAC_FILTER_EN
  logic [47:0] dst_q;
  logic        dst_ok;
  assign dst_ok = (dst_q == STATION_MAC) || (dst_q == 48'hFFFF_FFFF_FFFF);
`else
  logic unused_station_mac;
  assign unused_station_mac = ^STATION_MAC;
`endif

  // Advance the running CRC by one nibble, least significant bit first
  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < 4; i++) begin
      if (crc_d[31] ^ phy_rxd[i]) begin
        crc_d = {crc_d[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_d = {crc_d[30:0], 1'b0};
      end
    end
  end

  assign byte_d    = {phy_rxd, lo_q};
  assign data_bad  = phase_q | (byte_cnt_q < 11'd4) | (crc_q != CRC_RESIDUE)
                   | err_q | ovr_q;
  assign rx_busy   = (state_q == S_HDR) || (state_q == S_DATA);
  assign dbg_state = state_q;

  // Frame FSM with header/data counters, CRC, FCS holdback and registered outputs
  always_ff @(posedge phy_rxclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      crc_q      <= 32'hFFFF_FFFF;
      hdr_cnt_q  <= '0;
      byte_cnt_q <= '0;
      phase_q    <= 1'b0;
      lo_q       <= '0;
      dly_q      <= '0;
      fid_lo_q   <= '0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frameid    <= '0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
`ifdef MII_RX_MAC_FILTER_EN
      dst_q      <= '0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          crc_q     <= 32'hFFFF_FFFF;
          hdr_cnt_q <= '0;
          err_q     <= 1'b0;
          ovr_q     <= 1'b0;
          if (phy_rxdv) begin
            if (phy_rxd == 4'h5) begin
              state_q <= S_PRE;
              err_q   <= phy_rxer;
            end else begin
              state_q <= S_DROP;
            end
          end
        end

        // At least one preamble nibble has already been seen in IDLE
        S_PRE: begin
          if (!phy_rxdv) begin
            state_q <= S_IDLE;
          end else begin
            if (phy_rxer) err_q <= 1'b1;
            if (phy_rxd == 4'hD) begin
              state_q <= S_HDR;
            end else if (phy_rxd != 4'h5) begin
              state_q <= S_DROP;
            end
          end
        end

        S_HDR: begin
          if (!phy_rxdv) begin
            frame_bad <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            if (phy_rxer) err_q <= 1'b1;
            crc_q      <= crc_d;
            hdr_cnt_q  <= hdr_cnt_q + 5'd1;
            byte_cnt_q <= '0;
            phase_q    <= 1'b0;
`ifdef MII_RX_MAC_FILTER_EN
            if (hdr_cnt_q < 5'd12) begin
              dst_q[{hdr_cnt_q[3:0], 2'b00} +: 4] <= phy_rxd;
            end
            if (hdr_cnt_q == HDR_LAST) begin
              state_q <= dst_ok ? S_DATA : S_DROP;
            end
`else
            if (hdr_cnt_q == HDR_LAST) begin
              state_q <= S_DATA;
            end
`endif
          end
        end

        S_DATA: begin
          if (!phy_rxdv) begin
            frame_good <= ~data_bad;
            frame_bad  <= data_bad;
            state_q    <= S_IDLE;
          end else begin
            if (phy_rxer) err_q <= 1'b1;
            crc_q <= crc_d;
            if (!phase_q) begin
              lo_q    <= phy_rxd;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              // The four newest bytes are held back: they may be the FCS
              dly_q   <= {dly_q[2:0], byte_d};
              if (byte_cnt_q != BYTE_SAT) begin
                byte_cnt_q <= byte_cnt_q + 11'd1;
              end
              if (byte_cnt_q >= 11'd4) begin
                if ({1'b0, byte_cnt_q} < EMIT_LIMIT) begin
                  rx_valid <= 1'b1;
                  rx_data  <= dly_q[3];
                  if (byte_cnt_q == 11'd4) fid_lo_q[7:0]  <= dly_q[3];
                  if (byte_cnt_q == 11'd5) fid_lo_q[15:8] <= dly_q[3];
                  if (byte_cnt_q == 11'd6) frameid <= {dly_q[3], fid_lo_q};
                end else begin
                  ovr_q <= 1'b1;
                end
              end
            end
          end
        end

        S_DROP: begin
          if (!phy_rxdv) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_rx_frame.sv
// Testbench for mii_rx_frame: directed and random frames checked against a
// frame-level model (expected payload queue, expected frame id, verdict counts).
`timescale 1ns/1ps
module tb_mii_rx_frame;

  localparam int          MAX_PAYLOAD = 1500;
  localparam logic [47:0] STATION_MAC = 48'h0000_0000_0001;
  localparam logic [47:0] BCAST       = 48'hFFFF_FFFF_FFFF;

  // Clock / reset / stimulus signals
  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rxd   = 4'h0;
  logic        rxdv  = 1'b0;
  logic        rxer  = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [23:0] frameid;
  logic        frame_good;
  logic        frame_bad;
  logic        rx_busy;
  logic [2:0]  unused_dbg_state;

  int checks   = 0;
  int errors   = 0;
  int good_cnt = 0;
  int bad_cnt  = 0;
  int mark_g   = 0;
  int mark_b   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  tx_q[$];
  logic [3:0]  nib_q[$];
  logic [23:0] exp_fid = 24'h0;
  logic [47:0] rdst;

  mii_rx_frame #(
    .MAX_PAYLOAD(MAX_PAYLOAD),
    .STATION_MAC(STATION_MAC)
  ) dut (
    .phy_rxclk (clk),
    .reset     (reset),
    .phy_rxd   (rxd),
    .phy_rxdv  (rxdv),
    .phy_rxer  (rxer),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frameid   (frameid),
    .frame_good(frame_good),
    .frame_bad (frame_bad),
    .rx_busy   (rx_busy),
    .dbg_state (unused_dbg_state)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every delivered byte must be the next expected payload byte
  always @(negedge clk) begin
    if (rx_valid) begin
      check("rx_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
    end
    if (frame_good || frame_bad) check("one_verdict", 32'(frame_good & frame_bad), 32'd0);
    if (frame_good) good_cnt++;
    if (frame_bad)  bad_cnt++;
  end

  // Build header + payload, then append the standard Ethernet FCS (reflected CRC-32)
  task automatic make_frame(input logic [47:0] dst, input int npay, input bit counting);
    logic [31:0] c;
    tx_q = {};
    for (int i = 0; i < 6; i++) tx_q.push_back(dst[8*i +: 8]);
    for (int i = 0; i < 6; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    tx_q.push_back(8'h08);
    tx_q.push_back(8'h00);
    for (int i = 0; i < npay; i++)
      tx_q.push_back(counting ? 8'(i + 1) : 8'($urandom_range(0, 255)));
    c = 32'hFFFF_FFFF;
    foreach (tx_q[i]) begin
      c = c ^ {24'd0, tx_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) tx_q.push_back(c[8*i +: 8]);
  endtask

  task automatic make_nibs();
    nib_q = {};
    repeat (15) nib_q.push_back(4'h5);
    nib_q.push_back(4'hD);
    foreach (tx_q[i]) begin
      nib_q.push_back(tx_q[i][3:0]);
      nib_q.push_back(tx_q[i][7:4]);
    end
  endtask

  // Model: the transmitted payload comes out, capped at MAX_PAYLOAD bytes
  task automatic expect_payload(input int npay);
    int n;
    n = (npay > MAX_PAYLOAD) ? MAX_PAYLOAD : npay;
    for (int i = 0; i < n; i++) exp_q.push_back(tx_q[14 + i]);
    if (n >= 3) exp_fid = {tx_q[16], tx_q[15], tx_q[14]};
  endtask

  // Drive n nibbles (-1 = all), optional rxer on one nibble, then rxdv low for gap cycles
  task automatic drive(input int n, input int er_idx, input bit drop, input int gap, input bit chk_busy);
    int lim;
    lim = (n < 0 || n > nib_q.size()) ? nib_q.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      rxdv = 1'b1;
      rxd  = nib_q[i];
      rxer = (i == er_idx);
      if (chk_busy && i == 40 && lim > 44) check("busy_hdr", 32'(rx_busy), 32'd1);
    end
    if (drop) begin
      @(negedge clk);
      rxdv = 1'b0;
      rxd  = 4'h0;
      rxer = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic verify(input string tag, input int ng, input int nb);
    repeat (4) @(negedge clk);
    check({tag, "_good"},    32'(good_cnt - mark_g), 32'(ng));
    check({tag, "_bad"},     32'(bad_cnt - mark_b),  32'(nb));
    check({tag, "_pending"}, 32'(exp_q.size()),      32'd0);
    check({tag, "_fid"},     32'(frameid),           32'(exp_fid));
    check({tag, "_idle"},    32'(rx_busy),           32'd0);
    mark_g = good_cnt;
    mark_b = bad_cnt;
    exp_q  = {};
  endtask

  initial begin
    int mode;
    int npay;
    int er;
    int idx;

`ifdef MII_RX_MAC_FILTER_EN
    rdst = BCAST;
`else
    rdst = {16'($urandom), 32'($urandom)};
`endif

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rx_valid),   32'd0);
    check("rst_data",  32'(rx_data),    32'd0);
    check("rst_fid",   32'(frameid),    32'd0);
    check("rst_good",  32'(frame_good), 32'd0);
    check("rst_bad",   32'(frame_bad),  32'd0);
    check("rst_busy",  32'(rx_busy),    32'd0);

    // rxdv already high at reset release on a non-preamble nibble: whole burst dropped
    rxdv = 1'b1;
    rxd  = 4'h3;
    @(negedge clk);
    make_frame(BCAST, 10, 1'b1);
    make_nibs();
    reset = 1'b0;
    drive(-1, -1, 1'b1, 2, 1'b0);
    verify("pickup", 0, 0);

    // Broadcast frame, counting payload 01..2E
    make_frame(BCAST, 46, 1'b1);
    expect_payload(46);
    make_nibs();
    drive(-1, -1, 1'b1, 2, 1'b1);
    verify("t1", 1, 0);
    check("t1_fid_const", 32'(frameid), 32'h0003_0201);

    // One payload bit flipped: bytes still delivered, verdict bad
    make_frame(BCAST, 46, 1'b1);
    tx_q[14 + 20] = tx_q[14 + 20] ^ 8'h08;
    expect_payload(46);
    make_nibs();
    drive(-1, -1, 1'b1, 2, 1'b1);
    verify("t2_crc", 0, 1);

    // rxer for one cycle in the payload
    make_frame(BCAST, 46, 1'b0);
    expect_payload(46);
    make_nibs();
    drive(-1, 16 + 28 + 30, 1'b1, 2, 1'b1);
    verify("t3_rxer", 0, 1);

    // Truncated after 10 header nibbles; then truncated inside the preamble
    make_frame(BCAST, 46, 1'b1);
    make_nibs();
    drive(16 + 10, -1, 1'b1, 2, 1'b0);
    verify("t4_hdr", 0, 1);
    drive(8, -1, 1'b1, 2, 1'b0);
    verify("t4_pre", 0, 0);

    // Only three bytes after the header
    make_frame(BCAST, 46, 1'b1);
    make_nibs();
    drive(16 + 28 + 6, -1, 1'b1, 2, 1'b1);
    verify("short", 0, 1);

    // Empty payload: only FCS in DATA, good, frame id kept
    make_frame(BCAST, 0, 1'b0);
    expect_payload(0);
    make_nibs();
    drive(-1, -1, 1'b1, 2, 1'b1);
    verify("empty", 1, 0);

    // Largest legal payload, then one byte over
    make_frame(BCAST, MAX_PAYLOAD, 1'b0);
    expect_payload(MAX_PAYLOAD);
    make_nibs();
    drive(-1, -1, 1'b1, 2, 1'b1);
    verify("max", 1, 0);
    make_frame(BCAST, MAX_PAYLOAD + 1, 1'b0);
    expect_payload(MAX_PAYLOAD + 1);
    make_nibs();
    drive(-1, -1, 1'b1, 2, 1'b1);
    verify("t5_over", 0, 1);

`ifdef MII_RX_MAC_FILTER_EN
    // Foreign destination dropped silently, own station accepted
    make_frame(48'h09_00_00_00_00_02, 46, 1'b0);
    make_nibs();
    drive(-1, -1, 1'b1, 2, 1'b1);
    verify("flt_other", 0, 0);
    make_frame(STATION_MAC, 46, 1'b0);
    expect_payload(46);
    make_nibs();
    drive(-1, -1, 1'b1, 2, 1'b1);
    verify("flt_station", 1, 0);
`endif

    // Reset in the middle of DATA after six payload bytes went out
    make_frame(BCAST, 20, 1'b0);
    make_nibs();
    for (int i = 0; i < 6; i++) exp_q.push_back(tx_q[14 + i]);
    drive(16 + 28 + 20, -1, 1'b0, 1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_valid", 32'(rx_valid),   32'd0);
    check("rstmid_good",  32'(frame_good), 32'd0);
    check("rstmid_bad",   32'(frame_bad),  32'd0);
    check("rstmid_busy",  32'(rx_busy),    32'd0);
    check("rstmid_data",  32'(rx_data),    32'd0);
    rxdv    = 1'b0;
    rxer    = 1'b0;
    rxd     = 4'h0;
    reset   = 1'b0;
    exp_fid = 24'h0;
    verify("rstmid", 0, 0);
    make_frame(BCAST, 30, 1'b0);
    expect_payload(30);
    make_nibs();
    drive(-1, -1, 1'b1, 2, 1'b1);
    verify("after_rst", 1, 0);

    // Back-to-back frames with a single idle cycle between them
    make_frame(rdst, 20, 1'b0);
    expect_payload(20);
    make_nibs();
    drive(-1, -1, 1'b1, 1, 1'b1);
    make_frame(rdst, 25, 1'b0);
    expect_payload(25);
    make_nibs();
    drive(-1, -1, 1'b1, 1, 1'b1);
    verify("b2b", 2, 0);

    // Random frames: clean, corrupted, rxer, or one stray trailing nibble
    for (int f = 0; f < 10; f++) begin
      mode = $urandom_range(0, 3);
      npay = $urandom_range(0, 64);
      er   = -1;
      make_frame(rdst, npay, 1'b0);
      if (mode == 1) begin
        idx = $urandom_range(14, tx_q.size() - 1);
        tx_q[idx] = tx_q[idx] ^ 8'(1 << $urandom_range(0, 7));
      end
      expect_payload(npay);
      make_nibs();
      if (mode == 2) er = $urandom_range(16, nib_q.size() - 1);
      if (mode == 3) nib_q.push_back(4'($urandom_range(0, 15)));
      drive(-1, er, 1'b1, $urandom_range(1, 3), 1'b1);
      verify($sformatf("rnd%0d_m%0d", f, mode), (mode == 0) ? 1 : 0, (mode == 0) ? 0 : 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
